// File: rtl/instr_loader.sv
// UART byte-stream instruction loader: packs bytes MSB-first into words, writes them to
// instruction memory and holds the MIPS core in reset until loading ends. Optional macro: INSTR_LOADER_TIMEOUT_EN.
module instr_loader #(
    parameter int          MEM_DEPTH      = 256,
    parameter logic [31:0] HALT_WORD      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        rearm,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic [31:0] word_count,
    output logic        err_timeout
);

    typedef enum logic [1:0] {S_RECV, S_WRITE, S_DONE} state_t;

    localparam logic [31:0] LAST_ADDR = 32'(MEM_DEPTH - 1);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [31:0] assembled;
    logic        at_end;

`ifdef INSTR_LOADER_TIMEOUT_EN
    localparam logic [31:0] GAP_LIMIT = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] gap_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    // Only the three most recent bytes need keeping; the fourth arrives on rx_data.
    assign assembled = {shift, rx_data};
    assign at_end    = (wr_data == HALT_WORD) || (wr_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_RECV;
            byte_cnt   <= 2'd0;
            shift      <= 24'd0;
            wr_en      <= 1'b0;
            wr_addr    <= 32'd0;
            wr_data    <= 32'd0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            word_count <= 32'd0;
`ifdef INSTR_LOADER_TIMEOUT_EN
            gap_cnt     <= 32'd0;
            err_timeout <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_RECV: begin
                    if (rx_done) begin
                        shift    <= assembled[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wr_data <= assembled;
                            wr_en   <= 1'b1;
                            state   <= S_WRITE;
                        end
                    end
`ifdef INSTR_LOADER_TIMEOUT_EN
                    else if (byte_cnt != 2'd0) begin
                        if (gap_cnt == GAP_LIMIT) begin
                            byte_cnt    <= 2'd0;
                            shift       <= 24'd0;
                            err_timeout <= 1'b1;
                            gap_cnt     <= 32'd0;
                        end else begin
                            gap_cnt <= gap_cnt + 32'd1;
                        end
                    end
`endif
                end
                S_WRITE: begin
                    // A byte landing during the write cycle starts the next word.
                    if (rx_done) begin
                        shift    <= assembled[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    word_count <= word_count + 32'd1;
                    if (at_end) begin
                        state     <= S_DONE;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        wr_addr <= wr_addr + 32'd1;
                        state   <= S_RECV;
                    end
                end
                S_DONE: begin
                    if (rearm) begin
                        wr_addr    <= 32'd0;
                        word_count <= 32'd0;
                        byte_cnt   <= 2'd0;
                        cpu_hold   <= 1'b1;
                        load_done  <= 1'b0;
                        state      <= S_RECV;
`ifdef INSTR_LOADER_TIMEOUT_EN
                        err_timeout <= 1'b0;
`endif
                    end
                end
                default: state <= S_RECV;
            endcase
`ifdef INSTR_LOADER_TIMEOUT_EN
            if (rx_done) begin
                gap_cnt <= 32'd0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table-driven word loads plus hand-written corner sequences,
// with a write scoreboard per DUT instance (default depth and MEM_DEPTH=4).
module tb_instr_loader;

    typedef struct {
        logic        do_reset;
        logic [31:0] word;
        logic [31:0] addr;
        logic [31:0] count;
        logic        done;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        rx_done_a, rx_done_b;
    logic [7:0]  rx_data_a, rx_data_b;
    logic        rearm_a, rearm_b;
    logic        wr_en_a, wr_en_b;
    logic [31:0] wr_addr_a, wr_addr_b;
    logic [31:0] wr_data_a, wr_data_b;
    logic        cpu_hold_a, cpu_hold_b;
    logic        load_done_a, load_done_b;
    logic [31:0] word_count_a, word_count_b;
    logic        err_timeout_a, err_timeout_b;

    int  vectors = 0;
    int  miscompares = 0;
    wr_t sb_a[$];
    wr_t sb_b[$];
    vec_t tbl[4];

    instr_loader #(.MEM_DEPTH(256), .HALT_WORD(32'h0), .TIMEOUT_CYCLES(50)) dut_a (
        .clk(clk), .rst(rst), .rx_done(rx_done_a), .rx_data(rx_data_a), .rearm(rearm_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .cpu_hold(cpu_hold_a),
        .load_done(load_done_a), .word_count(word_count_a), .err_timeout(err_timeout_a)
    );

    instr_loader #(.MEM_DEPTH(4), .HALT_WORD(32'h0), .TIMEOUT_CYCLES(50)) dut_b (
        .clk(clk), .rst(rst), .rx_done(rx_done_b), .rx_data(rx_data_b), .rearm(rearm_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .cpu_hold(cpu_hold_b),
        .load_done(load_done_b), .word_count(word_count_b), .err_timeout(err_timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every observed write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (wr_en_a) begin
            vectors++;
            if (sb_a.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write_a: got addr=%h data=%h, expected no write", wr_addr_a, wr_data_a);
            end else begin
                e = sb_a.pop_front();
                if (wr_addr_a !== e.addr || wr_data_a !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL write_a: got addr=%h data=%h, expected addr=%h data=%h", wr_addr_a, wr_data_a, e.addr, e.data);
                end
            end
        end
        if (wr_en_b) begin
            vectors++;
            if (sb_b.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write_b: got addr=%h data=%h, expected no write", wr_addr_b, wr_data_b);
            end else begin
                e = sb_b.pop_front();
                if (wr_addr_b !== e.addr || wr_data_b !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL write_b: got addr=%h data=%h, expected addr=%h data=%h", wr_addr_b, wr_data_b, e.addr, e.data);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        rx_done_a = 1'b0;
        rx_done_b = 1'b0;
        rearm_a = 1'b0;
        rearm_b = 1'b0;
        tick(1);
        rst = 1'b1;
    endtask

    task automatic pushExp(input bit sel, input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        if (!sel) sb_a.push_back(e);
        else      sb_b.push_back(e);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit sel);
        if (!sel) begin
            rx_done_a = 1'b1;
            rx_data_a = b;
        end else begin
            rx_done_b = 1'b1;
            rx_data_b = b;
        end
        tick(1);
        rx_done_a = 1'b0;
        rx_done_b = 1'b0;
    endtask

    // Leaves the caller one step after the edge that sampled the 4th byte.
    task automatic applyStimulus(input logic [31:0] w, input int gap, input bit sel);
        for (int i = 0; i < 4; i++) begin
            sendByte(w[31-8*i -: 8], sel);
            if (i < 3) tick(gap);
        end
    endtask

    task automatic pulseRearmA();
        rearm_a = 1'b1;
        tick(1);
        rearm_a = 1'b0;
    endtask

    task automatic waitDrain(input bit sel);
        for (int i = 0; i < 20; i++) begin
            if ((!sel && sb_a.size() == 0) || (sel && sb_b.size() == 0)) break;
            tick(1);
        end
        vectors++;
        if (!sel && sb_a.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain_a: %0d writes outstanding, expected 0", sb_a.size());
        end
        if (sel && sb_b.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain_b: %0d writes outstanding, expected 0", sb_b.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        rx_done_a = 1'b0; rx_data_a = 8'h00; rearm_a = 1'b0;
        rx_done_b = 1'b0; rx_data_b = 8'h00; rearm_b = 1'b0;

        tbl[0] = '{1'b1, 32'h2008_0005, 32'd0, 32'd1, 1'b0};
        tbl[1] = '{1'b0, 32'h2009_0007, 32'd1, 32'd2, 1'b0};
        tbl[2] = '{1'b1, 32'h8C01_0000, 32'd0, 32'd1, 1'b0};
        tbl[3] = '{1'b0, 32'h0000_0000, 32'd1, 32'd2, 1'b1};

        doReset();
        checkOutput("reset_wr_en", {31'd0, wr_en_a}, 32'd0);
        checkOutput("reset_wr_addr", wr_addr_a, 32'd0);
        checkOutput("reset_wr_data", wr_data_a, 32'd0);
        checkOutput("reset_cpu_hold", {31'd0, cpu_hold_a}, 32'd1);
        checkOutput("reset_load_done", {31'd0, load_done_a}, 32'd0);
        checkOutput("reset_word_count", word_count_a, 32'd0);
        checkOutput("reset_err_timeout", {31'd0, err_timeout_a}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            if (tbl[v].do_reset) doReset();
            pushExp(1'b0, tbl[v].addr, tbl[v].word);
            applyStimulus(tbl[v].word, 2, 1'b0);
            checkOutput("tbl_wr_en_latency", {31'd0, wr_en_a}, 32'd1);
            checkOutput("tbl_wr_addr", wr_addr_a, tbl[v].addr);
            tick(1);
            checkOutput("tbl_wr_en_one_cycle", {31'd0, wr_en_a}, 32'd0);
            checkOutput("tbl_word_count", word_count_a, tbl[v].count);
            checkOutput("tbl_load_done", {31'd0, load_done_a}, {31'd0, tbl[v].done});
            checkOutput("tbl_cpu_hold", {31'd0, cpu_hold_a}, {31'd0, ~tbl[v].done});
        end

        // After the halt word further bytes are ignored and the address stays put.
        applyStimulus(32'hFFFF_FFFF, 0, 1'b0);
        tick(3);
        checkOutput("done_ignore_addr", wr_addr_a, 32'd1);
        checkOutput("done_ignore_count", word_count_a, 32'd2);
        checkOutput("done_ignore_load_done", {31'd0, load_done_a}, 32'd1);

        pulseRearmA();
        checkOutput("rearm_cpu_hold", {31'd0, cpu_hold_a}, 32'd1);
        checkOutput("rearm_load_done", {31'd0, load_done_a}, 32'd0);
        checkOutput("rearm_word_count", word_count_a, 32'd0);
        checkOutput("rearm_wr_addr", wr_addr_a, 32'd0);
        pushExp(1'b0, 32'd0, 32'hAABB_CCDD);
        applyStimulus(32'hAABB_CCDD, 1, 1'b0);
        tick(1);
        checkOutput("rearm_load_count", word_count_a, 32'd1);
        checkOutput("rearm_load_hold", {31'd0, cpu_hold_a}, 32'd1);

        // Rearm while still receiving must not restart the address sequence.
        pulseRearmA();
        pushExp(1'b0, 32'd1, 32'h0102_0304);
        applyStimulus(32'h0102_0304, 0, 1'b0);
        tick(1);
        checkOutput("rearm_ignored_count", word_count_a, 32'd2);
        checkOutput("rearm_ignored_addr", wr_addr_a, 32'd2);

        sendByte(8'h55, 1'b0);
        sendByte(8'h66, 1'b0);
        doReset();
        pushExp(1'b0, 32'd0, 32'h1122_3344);
        applyStimulus(32'h1122_3344, 0, 1'b0);
        tick(1);
        checkOutput("midword_reset_count", word_count_a, 32'd1);
        waitDrain(1'b0);

        // Back-to-back bytes: byte 0 of the second word arrives in the write cycle.
        doReset();
        pushExp(1'b0, 32'd0, 32'hCAFE_BABE);
        pushExp(1'b0, 32'd1, 32'h1234_5678);
        applyStimulus(32'hCAFE_BABE, 0, 1'b0);
        applyStimulus(32'h1234_5678, 0, 1'b0);
        checkOutput("b2b_wr_en", {31'd0, wr_en_a}, 32'd1);
        tick(1);
        checkOutput("b2b_count", word_count_a, 32'd2);
        waitDrain(1'b0);

        doReset();
        sendByte(8'hDE, 1'b0);
        sendByte(8'hAD, 1'b0);
        tick(60);
`ifdef INSTR_LOADER_TIMEOUT_EN
        checkOutput("gap_err_timeout", {31'd0, err_timeout_a}, 32'd1);
        pushExp(1'b0, 32'd0, 32'h0102_0304);
`else
        checkOutput("gap_err_timeout", {31'd0, err_timeout_a}, 32'd0);
        pushExp(1'b0, 32'd0, 32'hDEAD_0102);
`endif
        checkOutput("gap_no_write_count", word_count_a, 32'd0);
        applyStimulus(32'h0102_0304, 0, 1'b0);
        waitDrain(1'b0);
        tick(2);
        checkOutput("gap_count", word_count_a, 32'd1);

        // Depth-4 instance: stops at the last address without wrapping.
        doReset();
        for (int i = 0; i < 4; i++) begin
            pushExp(1'b1, 32'(i), {4{8'(8'h11 * (i + 1))}});
            applyStimulus({4{8'(8'h11 * (i + 1))}}, 0, 1'b1);
        end
        checkOutput("depth_last_wr_en", {31'd0, wr_en_b}, 32'd1);
        checkOutput("depth_last_addr", wr_addr_b, 32'd3);
        tick(1);
        checkOutput("depth_load_done", {31'd0, load_done_b}, 32'd1);
        checkOutput("depth_cpu_hold", {31'd0, cpu_hold_b}, 32'd0);
        checkOutput("depth_count", word_count_b, 32'd4);
        applyStimulus(32'h5555_5555, 0, 1'b1);
        tick(3);
        waitDrain(1'b1);
        checkOutput("depth_no_wrap_addr", wr_addr_b, 32'd3);
        checkOutput("depth_no_wrap_count", word_count_b, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

UART-side instruction loader for the pipelined MIPS. It consumes the byte stream from the UART receiver and packs it into 32-bit words, MSB first. Each word is written to instruction memory at consecutive word addresses starting at 0. It holds the CPU in reset until a halt word or the last memory address has been written, then releases the core for execution and debug dump.

## Interface
Parameters:
- MEM_DEPTH, 256: instruction memory depth in words; the last writable address is MEM_DEPTH-1.
- HALT_WORD, 32'h00000000: word value that terminates loading.
- TIMEOUT_CYCLES, 100000: inter-byte gap limit. Used only with INSTR_LOADER_TIMEOUT_EN.

Ports:
- clk, input, 1: system clock. Single clock domain.
- rst, input, 1: synchronous, active-low reset.
- rx_done, input, 1: one-cycle pulse from the UART receiver; a byte is valid on rx_data.
- rx_data, input, 8: received byte.
- rearm, input, 1: one-cycle pulse. Restarts loading from address 0; honoured only in S_DONE.
- wr_en, output, 1: instruction memory write strobe, one cycle per word.
- wr_addr, output, 32: word address of the current write.
- wr_data, output, 32: assembled instruction.
- cpu_hold, output, 1: keeps the MIPS in soft reset while loading.
- load_done, output, 1: level, high in S_DONE.
- word_count, output, 32: number of words written since the last reset or rearm.
- err_timeout, output, 1: sticky flag, set on an inter-byte timeout.

## Operation
- States:
  - S_RECV: collect bytes.
  - S_WRITE: issue a one-cycle write.
  - S_DONE: loading finished.
- Reset (rst=0 at a clk edge) sets:
  - state=S_RECV, byte_cnt=0, shift register=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - cpu_hold=1, load_done=0, word_count=0, err_timeout=0.
- S_RECV, on each rx_done:
  - shift = {shift[23:0], rx_data}; byte_cnt increments mod 4.
  - On the 4th byte (byte_cnt==3): latch wr_data = {shift[23:0], rx_data}, go to S_WRITE.
- S_WRITE:
  - wr_en=1 for exactly one cycle at the current wr_addr.
  - Next cycle: word_count increments.
  - If wr_data==HALT_WORD or wr_addr==MEM_DEPTH-1: go to S_DONE and leave wr_addr unchanged.
  - Otherwise: wr_addr increments and the block returns to S_RECV.
- An rx_done arriving in the S_WRITE cycle is still accepted as byte 0 of the next word. Byte assembly runs independently of the write strobe.
- S_DONE:
  - cpu_hold=0, load_done=1. rx_done is ignored and the shift register is frozen.
  - On rearm: wr_addr=0, word_count=0, byte_cnt=0, cpu_hold=1, load_done=0, go to S_RECV. err_timeout is cleared by rearm.
- rearm outside S_DONE has no effect.
- Reset mid-word discards the partial bytes. Memory contents already written are not touched.
- The halt word is itself written to memory, so the core stops on it.

## Timing
- Latency from the 4th rx_done edge to wr_en: 1 cycle. wr_en is high for 1 cycle.
- cpu_hold falls and load_done rises on the cycle after the final wr_en.
- wr_addr and wr_data are stable during the wr_en cycle and stay held until the next write.
- word_count updates on the cycle after wr_en.
- Address arithmetic: 32-bit unsigned. Termination at MEM_DEPTH-1 prevents wrap.
- byte_cnt wraps 3→0 on the 4th byte.

## Configuration
- INSTR_LOADER_TIMEOUT_EN defined:
  - A gap counter clears on every rx_done and counts while byte_cnt!=0 in S_RECV.
  - On reaching TIMEOUT_CYCLES-1: byte_cnt=0, the shift register is cleared, and err_timeout is set (sticky).
  - No write occurs, and wr_addr is unchanged.
- INSTR_LOADER_TIMEOUT_EN undefined:
  - No gap counter is built. err_timeout is tied to 0.
  - Partial words wait indefinitely for their remaining bytes.

## Test plan
- Reset then 8 bytes 20 08 00 05 / 20 09 00 07 → wr_en pulses writing addr0=0x20080005 and addr1=0x20090007; word_count=2; cpu_hold=1.
- Bytes 8C 01 00 00 then 00 00 00 00 → addr0=0x8C010000, addr1=0x00000000 written; 1 cycle later load_done=1, cpu_hold=0; further rx_done produce no wr_en.
- MEM_DEPTH=4, stream of 4 non-halt words → writes at 0..3, S_DONE after address 3, wr_addr stays 3, no wrap.
- In S_DONE pulse rearm, send AA BB CC DD → write at addr0=0xAABBCCDD, word_count=1, cpu_hold=1 again.
- rst low after 2 bytes of a word, then 4 bytes 11 22 33 44 → single write at addr0=0x11223344, no stale bytes.
- With INSTR_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=50: send 2 bytes, idle 60 cycles, then 01 02 03 04 → err_timeout=1, no write during the gap, then addr0=0x01020304.
